// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Transmit-only UART framer. Accepts one byte through a valid/ready handshake,
// then drives the serial line with: start bit (0), eight data bits LSB-first,
// an optional odd-parity bit, and one stop bit (1). Each bit lasts exactly
// CLKS_PER_BIT clock cycles. All outputs are registered.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (2..65535)
//   PARITY_EN     1 = insert odd-parity bit after the data, 0 = omit it
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_valid    byte offered for transmission
//   tx_data     byte to send, sampled on acceptance
//   tx_ready    high only while idle (able to accept)
//   tx_out      serial line, idle high
//   busy        frame in progress
//   frame_done  one-cycle pulse after the stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  // Timer width; guarded so a degenerate parameter still yields a legal vector.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          tx_out_r;
  logic          tx_ready_r;
  logic          busy_r;
  logic          frame_done_r;

  logic          bit_tick_s;
  logic [2:0]    bit_nxt_s;

  // Odd parity: the extra bit makes the total count of ones odd,
  // i.e. it is 1 exactly when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // End of the current bit period.
  assign bit_tick_s = (timer_r == TIMER_MAX);

  // Index of the data bit that follows the current one (wraps 7 -> 0).
  assign bit_nxt_s  = bit_cnt_r + 3'd1;

  assign tx_out     = tx_out_r;
  assign tx_ready   = tx_ready_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Baud timer: parked at 0 while idle so the start bit after acceptance
  // gets a full period; wraps to 0 on every bit_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (state_r == IDLE) begin
      timer_r <= '0;
    end else if (bit_tick_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  // Framing FSM with bit counter, byte latch and registered outputs.
  // tx_out is loaded with the level belonging to the state being entered,
  // so the line changes on the same edge as the state.
  // shift_r only loads in IDLE; it is indexed rather than shifted so the
  // parity bit can be taken over the whole latched byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'd0;
      tx_out_r     <= 1'b1;
      tx_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tx_valid) begin
            shift_r    <= tx_data;
            bit_cnt_r  <= 3'd0;
            state_r    <= START;
            tx_out_r   <= 1'b0;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            tx_out_r   <= 1'b1;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end

        START: begin
          if (bit_tick_s) begin
            state_r  <= DATA;
            tx_out_r <= shift_r[bit_cnt_r];
          end
        end

        DATA: begin
          if (bit_tick_s) begin
            bit_cnt_r <= bit_nxt_s;
            if (bit_cnt_r != 3'd7) begin
              tx_out_r <= shift_r[bit_nxt_s];
            end else if (PARITY_EN != 0) begin
              state_r  <= PARITY;
              tx_out_r <= odd_parity(shift_r);
            end else begin
              state_r  <= STOP;
              tx_out_r <= 1'b1;
            end
          end
        end

        PARITY: begin
          if (bit_tick_s) begin
            state_r  <= STOP;
            tx_out_r <= 1'b1;
          end
        end

        STOP: begin
          if (bit_tick_s) begin
            state_r      <= IDLE;
            tx_out_r     <= 1'b1;
            tx_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end
        end

        default: begin
          // Unreachable encodings recover to a quiet idle line.
          state_r    <= IDLE;
          bit_cnt_r  <= 3'd0;
          tx_out_r   <= 1'b1;
          tx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, meaning clock cycles per bit period (legal range 2..65535).
REQ-002 Parameter PARITY_EN, default 1, meaning 1 inserts an odd-parity bit after the data bits and 0 omits it.
REQ-003 The port list SHALL be exactly as follows; one clock, reset asynchronous and active-low.
- clk  input  1  sole clock, all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_valid  input  1  byte offered for transmission.
- tx_data  input  8  byte to send, sampled on acceptance.
- tx_ready  output  1  controller idle and able to accept.
- tx_out  output  1  serial line, idle high, registered.
- busy  output  1  frame in progress (state != IDLE).
- frame_done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-004 The block SHALL contain a baud timer of width $clog2(CLKS_PER_BIT): counts 0..CLKS_PER_BIT-1 and asserts bit_tick internally when the count equals CLKS_PER_BIT-1, then wraps to 0.
REQ-005 The baud timer SHALL be held at 0 in IDLE and cleared on the acceptance edge, so every bit lasts exactly CLKS_PER_BIT cycles.
REQ-006 The block SHALL contain a 3-bit bit counter: cleared on acceptance, incremented on bit_tick in DATA, and wraps 7->0 when leaving DATA.
REQ-007 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-008 Acceptance SHALL occur on a rising edge where tx_valid=1 and tx_ready=1: latch tx_data into a shift register and go IDLE->START.
REQ-009 tx_ready SHALL equal 1 only in IDLE; tx_valid and tx_data SHALL be ignored in all other states.
REQ-010 Transitions SHALL occur only on bit_tick:
- START->DATA.
- DATA->DATA while bit counter < 7.
- DATA->PARITY when bit counter = 7 and PARITY_EN=1.
- DATA->STOP when bit counter = 7 and PARITY_EN=0.
- PARITY->STOP.
- STOP->IDLE.
REQ-011 tx_out SHALL be registered from next-state: 1 in IDLE and STOP, 0 in START, data bit[bit counter] LSB-first in DATA, and ~^data (odd parity over the latched byte) in PARITY.
REQ-012 tx_out SHALL go low on the clock edge following acceptance and remain low for CLKS_PER_BIT cycles.
REQ-013 A frame SHALL occupy 11*CLKS_PER_BIT cycles with PARITY_EN=1 and 10*CLKS_PER_BIT cycles with PARITY_EN=0, from the first low cycle to the return to IDLE.
REQ-014 frame_done SHALL pulse high for exactly one cycle, in the cycle after the STOP->IDLE edge.
REQ-015 Back-to-back operation: with tx_valid held high, the next byte SHALL be accepted on the first IDLE cycle, giving exactly one idle-high cycle between stop bit and next start bit.
REQ-016 The latched byte SHALL not change while busy=1, even if tx_data changes.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, timer=0, bit counter=0, shift register=0, tx_out=1, tx_ready=1, busy=0, frame_done=0.
REQ-018 Reset asserted mid-frame SHALL abort the frame with the line returned high; no partial bits SHALL resume after rst_n deasserts.
REQ-019 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-020 Send 0xA5 with PARITY_EN=1 -> tx_out = 0, then 1,0,1,0,0,1,0,1, then parity 1, then stop 1, each held 4 cycles; frame_done pulses once, 44 cycles after the first low.
REQ-021 Send 0x00 with PARITY_EN=0 -> 9 consecutive low bits (36 cycles), then a 4-cycle stop bit, 40 cycles total; parity slot absent.
REQ-022 tx_valid held high with 0xFF then 0x01 -> parity bits 1 then 0; exactly 1 high cycle between the first stop bit and the second start bit.
REQ-023 Change tx_data and pulse tx_valid during DATA -> transmitted bits unchanged; tx_ready stays 0 until IDLE.
REQ-024 Assert rst_n=0 asynchronously mid-DATA -> tx_out=1 and tx_ready=1 before the next clock edge; frame_done never pulses; a subsequent 0x3C frame is bit-exact.
REQ-025 With CLKS_PER_BIT=5208, send 0x55 -> each bit lasts exactly 5208 cycles and the frame totals 57288 cycles.
